// File: rtl/row_loader_float32_pkg.sv
// rtl/row_loader_float32_pkg.sv - shared types and constants for the float32 row loader
package row_loader_float32_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    localparam int DEFAULT_INPUTS  = 1024;
    localparam int DEFAULT_CNT_W   = $clog2(DEFAULT_INPUTS) + 1;
    localparam int DEFAULT_LAT_W   = $clog2($clog2(DEFAULT_INPUTS) + 1);

    // Count must reach NUMBER_OF_INPUTS itself, hence the extra bit.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int lat_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/row_loader_float32.sv
// rtl/row_loader_float32.sv - packs a float32 stream into a tree row and collects the tree sum
module row_loader_float32
    import row_loader_float32_pkg::*;
#(
    parameter int NUMBER_OF_INPUTS = 1024,
    parameter int BITS_PER_SYMBOL  = 32,
    parameter int TREE_LATENCY     = $clog2(NUMBER_OF_INPUTS)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_n,
    input  logic [BITS_PER_SYMBOL-1:0]                  s_data_i,
    input  logic                                        s_valid_i,
    input  logic                                        s_last_i,
    output logic                                        s_ready_o,
    output logic [NUMBER_OF_INPUTS*BITS_PER_SYMBOL-1:0] row_o,
    input  logic [BITS_PER_SYMBOL-1:0]                  sum_i,
    output logic [BITS_PER_SYMBOL-1:0]                  res_data_o,
    output logic                                        res_valid_o,
    input  logic                                        res_ready_i,
    output logic [$clog2(NUMBER_OF_INPUTS):0]           count_o,
    output logic                                        busy_o
);

    localparam int CW = cnt_width(NUMBER_OF_INPUTS);
    localparam int LW = lat_width(TREE_LATENCY);

    state_t                                      state_q, state_d;
    logic [NUMBER_OF_INPUTS*BITS_PER_SYMBOL-1:0] row_q, row_d;
    logic [CW-1:0]                               cnt_q, cnt_d;
    logic [LW-1:0]                               lat_q, lat_d;
    logic [BITS_PER_SYMBOL-1:0]                  res_q, res_d;
    logic                                        rvalid_q, rvalid_d;
    logic                                        accept;

    assign accept = s_valid_i && (state_q == FILL);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        res_d    = res_q;
        rvalid_d = rvalid_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < NUMBER_OF_INPUTS; k++) begin
                        if (cnt_q == CW'(k)) begin
                            row_d[k*BITS_PER_SYMBOL +: BITS_PER_SYMBOL] = s_data_i;
                        end
                    end
                    if (cnt_q < CW'(NUMBER_OF_INPUTS)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (s_last_i || (cnt_q == CW'(NUMBER_OF_INPUTS - 1))) begin
                        state_d = WAIT;
                        lat_d   = LW'(TREE_LATENCY);
                    end
                end
            end
            WAIT: begin
                // The row settled at the entry edge; the tree needs TREE_LATENCY
                // edges after that, so sample on the edge following the countdown.
                if (lat_q == '0) begin
                    res_d    = sum_i;
                    rvalid_d = 1'b1;
                    state_d  = RESULT;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            RESULT: begin
                if (res_ready_i) begin
                    rvalid_d = 1'b0;
                    row_d    = {NUMBER_OF_INPUTS{FP32_ZERO}};
                    cnt_d    = '0;
                    state_d  = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            row_q    <= '0;
            cnt_q    <= '0;
            lat_q    <= '0;
            res_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            res_q    <= res_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign s_ready_o   = (state_q == FILL);
    assign busy_o      = (state_q != FILL);
    assign row_o       = row_q;
    assign res_data_o  = res_q;
    assign res_valid_o = rvalid_q;
    assign count_o     = cnt_q;

endmodule

// File: tb/tb_row_loader_float32.sv
// tb/tb_row_loader_float32.sv - self-checking bench for row_loader_float32 with a behavioural tree
module tb_row_loader_float32;

    localparam int N   = 4;
    localparam int B   = 32;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [B-1:0]   s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           s_ready;
    logic [N*B-1:0] row;
    logic [B-1:0]   sum;
    logic [B-1:0]   res_data;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [2:0]     count;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    row_loader_float32 #(
        .NUMBER_OF_INPUTS(N),
        .BITS_PER_SYMBOL (B),
        .TREE_LATENCY    (LAT)
    ) dut (
        .clk_i      (clk),
        .rst_n      (rst_n),
        .s_data_i   (s_data),
        .s_valid_i  (s_valid),
        .s_last_i   (s_last),
        .s_ready_o  (s_ready),
        .row_o      (row),
        .sum_i      (sum),
        .res_data_o (res_data),
        .res_valid_o(res_valid),
        .res_ready_i(res_ready),
        .count_o    (count),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // float32 <-> real for the exactly representable values used here
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    // Behavioural adder tree: pairwise sums, two register stages.
    logic [31:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p1 <= r2f((f2r(row[31:0]) + f2r(row[63:32])) + (f2r(row[95:64]) + f2r(row[127:96])));
        p2 <= p1;
    end
    assign sum = p2;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic last, input bit gap);
        s_data  = w;
        s_valid = 1'b1;
        s_last  = last;
        @(negedge clk);
        chk("s_ready_in_fill", 128'(s_ready), 128'(1));
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (gap && !last) begin
            s_last = 1'b1;
            s_data = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            s_last = 1'b0;
        end
    endtask

    // Pushes a row, checks packing, latency, result, optional backpressure and release.
    task automatic run_row(input int n, input logic [3:0][31:0] w, input bit gap,
                           input bit rdy_early, input bit bp, input logic [31:0] exp_sum);
        logic [127:0] exp_row;
        logic [31:0]  held;
        int           k;
        exp_row = '0;
        for (int i = 0; i < n; i++) exp_row[i*32 +: 32] = w[i];
        res_ready = rdy_early;
        for (int i = 0; i < n; i++) push_word(w[i], (i == n - 1) && (n < N || gap), gap);
        chk("row_packed", row, exp_row);
        chk("count_after_row", 128'(count), 128'(n));
        chk("busy_in_wait", 128'(busy), 128'(1));
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (res_valid) break;
        end
        chk("result_latency", 128'(k), 128'(LAT + 1));
        chk("res_data", 128'(res_data), 128'(exp_sum));
        chk("count_in_result", 128'(count), 128'(n));
        if (bp) begin
            held = res_data;
            s_valid = 1'b1;
            s_data  = 32'h4120_0000;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("bp_s_ready_low", 128'(s_ready), 128'(0));
                chk("bp_res_held", 128'({res_valid, res_data}), 128'({1'b1, held}));
                chk("bp_count_held", 128'(count), 128'(n));
            end
            s_valid = 1'b0;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("release_state", 128'({res_valid, busy, s_ready, count}), 128'({3'b001, 3'd0}));
        chk("release_row_zero", row, 128'(0));
    endtask

    typedef struct {
        int               n;
        logic [3:0][31:0] w;
        bit               gap;
        bit               rdy_early;
        bit               bp;
        logic [31:0]      exp_sum;
    } vec_t;

    vec_t vecs[5];
    logic [3:0][31:0] rw;
    real   acc;
    int    rn;

    initial begin
        vecs[0] = '{4, {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000}, 0, 0, 0, 32'h4120_0000};
        vecs[1] = '{2, {32'h0, 32'h0, 32'h3F00_0000, 32'h40A0_0000}, 0, 1, 0, 32'h40B0_0000};
        vecs[2] = '{4, {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000}, 0, 0, 1, 32'h4120_0000};
        vecs[3] = '{3, {32'h0, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000}, 1, 0, 0, 32'h40C0_0000};
        vecs[4] = '{1, {32'h0, 32'h0, 32'h0, 32'hC000_0000}, 0, 0, 0, 32'hC000_0000};

        #12;
        chk("reset_outputs", {row[N*B-1:0]}, 128'(0));
        chk("reset_ctrl", 128'({res_data, res_valid, busy, s_ready, count}), 128'({32'h0, 3'b001, 3'd0}));
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("early_ready_no_effect", 128'({res_valid, busy}), 128'(0));
        res_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++)
            run_row(vecs[v].n, vecs[v].w, vecs[v].gap, vecs[v].rdy_early, vecs[v].bp, vecs[v].exp_sum);

        // Reset one cycle into WAIT: everything clears, no stale result afterwards.
        for (int i = 0; i < N; i++) push_word(vecs[0].w[i], 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("midwait_reset_row", row, 128'(0));
        chk("midwait_reset_ctrl", 128'({res_data, res_valid, busy, s_ready, count}), 128'({32'h0, 3'b001, 3'd0}));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_result", 128'({res_valid, busy}), 128'(0));
        end
        @(posedge clk); #1;
        run_row(1, {32'h0, 32'h0, 32'h0, 32'hC000_0000}, 0, 0, 0, 32'hC000_0000);

        // Randomized rows against a plain sum of the accepted words.
        for (int t = 0; t < 10; t++) begin
            rn  = int'($urandom_range(1, N));
            rw  = '0;
            acc = 0.0;
            for (int i = 0; i < rn; i++) begin
                int iv;
                iv = int'($urandom_range(0, 40)) - 20;
                if (iv == 0) iv = 7;
                rw[i] = r2f(real'(iv));
                acc  += real'(iv);
            end
            run_row(rn, rw, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0, r2f(acc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
